// File: rtl/ico_sweep_ctrl.sv
// ----------------------------------------------------------------------------
// ico_sweep_ctrl : steps the ICO increment word from a start value to a stop value
// Revision: 1.0  initial release
// ----------------------------------------------------------------------------
`default_nettype none

module ico_sweep_ctrl #(
  parameter int                 INC_W    = 15,
  parameter int                 DWELL_W  = 16,
  parameter logic [INC_W-1:0]   IDLE_INC = 15'd13002
) (
  input  logic                clk50MHz,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [INC_W-1:0]    inc_start,
  input  logic [INC_W-1:0]    inc_stop,
  input  logic [INC_W-1:0]    inc_step,
  input  logic [DWELL_W-1:0]  dwell,
  output logic [INC_W-1:0]    increment,
  output logic                step_strobe,
  output logic                busy,
  output logic                done
);

  localparam logic [2:0] c_st_idle  = 3'd0;
  localparam logic [2:0] c_st_load  = 3'd1;
  localparam logic [2:0] c_st_dwell = 3'd2;
  localparam logic [2:0] c_st_step  = 3'd3;
  localparam logic [2:0] c_st_done  = 3'd4;

  localparam logic [DWELL_W-1:0] c_cnt_one = {{(DWELL_W-1){1'b0}}, 1'b1};

  logic [2:0]         r_state;
  logic [DWELL_W-1:0] r_cnt;
  logic [DWELL_W-1:0] r_dwell_max;
  logic [INC_W-1:0]   r_inc_start;
  logic [INC_W-1:0]   r_inc_stop;
  logic [INC_W-1:0]   r_inc_step;
  logic               r_dir_up;

  logic [INC_W:0]     w_sum;
  logic [INC_W:0]     w_diff;
  logic [INC_W-1:0]   w_step_val;
  logic               w_dwell_hit;

  // One extra bit keeps the step arithmetic from wrapping; the MSB of w_diff flags a borrow.
  always_comb begin
    w_sum  = {1'b0, increment} + {1'b0, r_inc_step};
    w_diff = {1'b0, increment} - {1'b0, r_inc_step};
    w_step_val = w_sum[INC_W-1:0];
    if (r_dir_up) begin
      if (w_sum >= {1'b0, r_inc_stop})
        w_step_val = r_inc_stop;
    end else begin
      w_step_val = w_diff[INC_W-1:0];
      if (w_diff[INC_W] || (w_diff <= {1'b0, r_inc_stop}))
        w_step_val = r_inc_stop;
    end
  end

  assign w_dwell_hit = (r_cnt == r_dwell_max);

  always_ff @(posedge clk50MHz) begin
    if (rst) begin
      r_state     <= c_st_idle;
      r_cnt       <= '0;
      r_dwell_max <= c_cnt_one;
      r_inc_start <= '0;
      r_inc_stop  <= '0;
      r_inc_step  <= '0;
      r_dir_up    <= 1'b1;
      increment   <= IDLE_INC;
      step_strobe <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      step_strobe <= 1'b0;
      done        <= 1'b0;
      // Abort outranks every transition, including the one into DONE.
      if (abort && (r_state != c_st_idle)) begin
        r_state <= c_st_idle;
        busy    <= 1'b0;
      end else begin
        case (r_state)
          c_st_idle: begin
            if (start) begin
              r_inc_start <= inc_start;
              r_inc_stop  <= inc_stop;
              r_inc_step  <= inc_step;
              r_dwell_max <= (dwell == '0) ? c_cnt_one : dwell;
              r_state     <= c_st_load;
              busy        <= 1'b1;
            end
          end
          c_st_load: begin
            increment   <= r_inc_start;
            step_strobe <= 1'b1;
            r_cnt       <= c_cnt_one;
            r_dir_up    <= (r_inc_stop >= r_inc_start);
            r_state     <= c_st_dwell;
          end
          c_st_dwell: begin
            if (w_dwell_hit) begin
              if ((increment == r_inc_stop) || (r_inc_step == '0)) begin
                r_state <= c_st_done;
                done    <= 1'b1;
              end else begin
                r_state <= c_st_step;
              end
            end else begin
              r_cnt <= r_cnt + c_cnt_one;
            end
          end
          c_st_step: begin
            increment   <= w_step_val;
            step_strobe <= 1'b1;
            r_cnt       <= c_cnt_one;
            r_state     <= c_st_dwell;
          end
          c_st_done: begin
            r_state <= c_st_idle;
            busy    <= 1'b0;
          end
          default: begin
            r_state <= c_st_idle;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire
